usb_ep_status_mp: RTL

Parametrised multi-port endpoint status memory for the USB core. It stores one DW-bit status word per entry in a 2^AW-entry RAM. It serves one never-stalled priority port (the USB protocol engine) and NS secondary ports (bus interface, DMA, debug) that are arbitrated round-robin. Over the previous single-aux design it adds per-bit write masks, read-valid strobes and an automatic zero-fill after reset.

---
 rtl/usb_ep_status_mp.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/usb_ep_status_mp.sv
// Multi-port endpoint status memory: one never-stalled priority port plus NS
// round-robin secondary ports sharing a 2^AW x DW RAM. It supports per-bit write
// masks, zero-reads, read-valid strobes and an optional zero-fill after reset.
module usb_ep_status_mp #(
    parameter int AW         = 8,
    parameter int DW         = 16,
    parameter int NS         = 2,
    parameter int INIT_CLEAR = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    p_addr,
    input  logic             p_read,
    input  logic             p_zero,
    input  logic             p_write,
    input  logic [DW-1:0]    p_wmask,
    input  logic [DW-1:0]    p_din,
    output logic [DW-1:0]    p_dout,
    output logic             p_valid,
    input  logic [NS*AW-1:0] s_addr,
    input  logic [NS-1:0]    s_read,
    input  logic [NS-1:0]    s_zero,
    input  logic [NS-1:0]    s_write,
    input  logic [NS*DW-1:0] s_wmask,
    input  logic [NS*DW-1:0] s_din,
    output logic [NS-1:0]    s_ready,
    output logic [NS*DW-1:0] s_dout,
    output logic [NS-1:0]    s_valid,
    output logic             init_done
);

    localparam int IW    = (NS > 1) ? $clog2(NS) : 1;
    localparam int DEPTH = 1 << AW;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state, state_next;
    logic [AW-1:0]   init_cnt;
    logic [IW-1:0]   rr_last;
    logic [DW-1:0]   mem [DEPTH];

    logic            p_req;
    logic [NS-1:0]   s_req;
    logic [NS-1:0]   grant;
    logic            sec_any;
    logic [IW-1:0]   sec_idx;
    int              srch;

    // Stage 1: registered operation heading into the RAM
    logic            s1_we, s1_rd, s1_zero;
    logic [NS:0]     s1_dst;
    logic [AW-1:0]   s1_addr;
    logic [DW-1:0]   s1_din, s1_mask;

    // Stage 2: RAM read data plus the flags that travel with it
    logic            s2_rd, s2_zero;
    logic [NS:0]     s2_dst;
    logic [DW-1:0]   rdata;

    // Priority wins outright; otherwise search upward from the port after rr_last
    always_comb begin
        p_req   = p_read | p_zero | p_write;
        s_req   = s_read | s_zero | s_write;
        grant   = '0;
        sec_any = 1'b0;
        sec_idx = '0;
        srch    = 0;
        if (state == RUN && !p_req) begin
            for (int k = 1; k <= NS; k++) begin
                srch = (int'(rr_last) + k) % NS;
                if (!sec_any && s_req[srch]) begin
                    sec_any = 1'b1;
                    sec_idx = IW'(srch);
                end
            end
        end
        if (sec_any) grant[sec_idx] = 1'b1;
    end

    assign s_ready = grant;

    // INIT ends once the last zero-fill address has been issued
    always_comb begin
        state_next = state;
        if (state == INIT && init_cnt == '1) state_next = RUN;
    end

    // State, fill counter, round-robin pointer and init_done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= (INIT_CLEAR != 0) ? INIT : RUN;
            init_cnt  <= '0;
            rr_last   <= IW'(NS - 1);
            init_done <= (INIT_CLEAR != 0) ? 1'b0 : 1'b1;
        end else begin
            state <= state_next;
            if (state == INIT) init_cnt <= init_cnt + 1'b1;
            if (sec_any) rr_last <= sec_idx;
            if (state == RUN) init_done <= 1'b1;
        end
    end

    // Capture the accepted operation (or the zero-fill write) into stage 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_we   <= 1'b0;
            s1_rd   <= 1'b0;
            s1_zero <= 1'b0;
            s1_dst  <= '0;
            s1_addr <= '0;
            s1_din  <= '0;
            s1_mask <= '0;
        end else if (state == INIT) begin
            s1_we   <= 1'b1;
            s1_rd   <= 1'b0;
            s1_zero <= 1'b0;
            s1_dst  <= '0;
            s1_addr <= init_cnt;
            s1_din  <= '0;
            s1_mask <= '1;
        end else if (p_req) begin
            s1_we   <= p_write;
            s1_rd   <= p_read | p_zero;
            s1_zero <= p_zero;
            s1_dst  <= {1'b1, {NS{1'b0}}};
            s1_addr <= p_addr;
            s1_din  <= p_din;
            s1_mask <= p_wmask;
        end else if (sec_any) begin
            s1_we   <= s_write[sec_idx];
            s1_rd   <= s_read[sec_idx] | s_zero[sec_idx];
            s1_zero <= s_zero[sec_idx];
            s1_dst  <= {1'b0, grant};
            s1_addr <= s_addr[sec_idx*AW +: AW];
            s1_din  <= s_din[sec_idx*DW +: DW];
            s1_mask <= s_wmask[sec_idx*DW +: DW];
        end else begin
            s1_we   <= 1'b0;
            s1_rd   <= 1'b0;
            s1_zero <= 1'b0;
            s1_dst  <= '0;
        end
    end

    // RAM: masked write and read of the old contents happen on the same edge
    always_ff @(posedge clk) begin
        if (s1_we) mem[s1_addr] <= (mem[s1_addr] & ~s1_mask) | (s1_din & s1_mask);
        rdata <= mem[s1_addr];
    end

    // Carry the read flags alongside the RAM access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_rd   <= 1'b0;
            s2_zero <= 1'b0;
            s2_dst  <= '0;
        end else begin
            s2_rd   <= s1_rd;
            s2_zero <= s1_zero;
            s2_dst  <= s1_dst;
        end
    end

    // Route the result to the requesting port and pulse its valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_dout  <= '0;
            p_valid <= 1'b0;
            s_dout  <= '0;
            s_valid <= '0;
        end else begin
            p_valid <= s2_rd & s2_dst[NS];
            if (s2_rd && s2_dst[NS]) p_dout <= s2_zero ? '0 : rdata;
            for (int i = 0; i < NS; i++) begin
                s_valid[i] <= s2_rd & s2_dst[i];
                if (s2_rd && s2_dst[i]) s_dout[i*DW +: DW] <= s2_zero ? '0 : rdata;
            end
        end
    end

endmodule
